// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes (common with the
// ALU control decoder) and the execute-unit state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Left shifter for SLL with a start/done interface toward the execute FSM.
// ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter; otherwise one bit per cycle.
module alu_shifter #(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

`ifdef ALU_FAST_SHIFT_EN

    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign done_o   = start_i;
    assign result_o = a_i << shamt_i;

`else

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i && (shamt_i != '0)) begin
            acc_d = a_i;
            cnt_d = shamt_i;
        end else if (cnt_q != '0) begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // A zero shift finishes at the start edge; otherwise the last shift is folded
    // into the result on the edge where cnt reaches one.
    assign done_o   = start_i ? (shamt_i == '0) : (cnt_q == SHW'(1));
    assign result_o = start_i ? a_i : (acc_q << 1);

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result, zero and signed-less-than flags behind a
// valid/ready handshake. ALU_FAST_SHIFT_EN selects a single-cycle SLL.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lt
);

    if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
        $error("alu_exec_unit: WIDTH must be a power of two and at least 8");
    end

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;

    logic             accept;
    logic             is_sll;
    logic             sh_start;
    logic             sh_done;
    logic [WIDTH-1:0] sh_result;
    logic [WIDTH-1:0] alu_res;
    logic             slt;

    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign is_sll   = (operation == OP_SLL);
    assign sh_start = accept & is_sll;
    assign slt      = $signed(op_a) < $signed(op_b);

    always_comb begin
        case (operation)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SUB:  alu_res = op_a + ~op_b + WIDTH'(1);
            default: alu_res = op_a + op_b;
        endcase
    end

    alu_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (sh_start),
        .a_i      (op_a),
        .shamt_i  (op_b[SHW-1:0]),
        .done_o   (sh_done),
        .result_o (sh_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        lt_d     = lt_q;
        if (accept) begin
            lt_d = slt;
            if (!is_sll) begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                state_d  = DONE;
            end else if (sh_done) begin
                result_d = sh_result;
                zero_d   = (sh_result == '0);
                state_d  = DONE;
            end else begin
                state_d  = BUSY;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (sh_done) begin
                        result_d = sh_result;
                        zero_d   = (sh_result == '0);
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            lt_q     <= lt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign lt        = lt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=64); honours ALU_FAST_SHIFT_EN
// when computing expected SLL latency.
module tb_alu_exec_unit;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLL = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        lt;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(
        .WIDTH(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_sll_lat(input int s);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        return (s == 0) ? 1 : s + 1;
`endif
    endfunction

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid  = 1'b1;
        operation = op;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        operation = C_ADD; op_a = '0; op_b = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", result); end
        checks++; if (zero !== 1'b0 || lt !== 1'b0) begin errors++; $display("FAIL reset_flags: got zero=%b lt=%b expected 0 0", zero, lt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        step(); step();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(C_ADD, 64'd5, 64'd7);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid=%b expected 1", out_valid); end
        checks++; if (result !== 64'd12 || zero !== 1'b0) begin errors++; $display("FAIL add_result: got %0h zero=%b expected c zero=0", result, zero); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_sub_branch();
        out_ready = 1'b1;
        drive(C_SUB, 64'd9, 64'd9);
        step();
        checks++; if (result !== 64'd0 || zero !== 1'b1 || lt !== 1'b0) begin errors++; $display("FAIL sub_equal: got %0h zero=%b lt=%b expected 0 1 0", result, zero, lt); end
        drive(C_SUB, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2);
        step();
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFB || zero !== 1'b0 || lt !== 1'b1) begin errors++; $display("FAIL sub_neg: got %0h zero=%b lt=%b expected fffffffffffffffb 0 1", result, zero, lt); end
        drive(C_SUB, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        in_valid = 1'b0;
        checks++; if (result !== 64'd2 || lt !== 1'b0) begin errors++; $display("FAIL sub_signed_lt: got %0h lt=%b expected 2 0", result, lt); end
        step();
    endtask

    task automatic run_sll(input logic [63:0] a, input logic [63:0] b, input int s,
                           input logic [63:0] exp, input string name);
        int cyc;
        int bad_ready;
        out_ready = 1'b1;
        drive(C_SLL, a, b);
        step();
        cyc = 1;
        bad_ready = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready !== 1'b0) bad_ready++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout: no out_valid after %0d cycles", name, cyc); end
        checks++; if (cyc != exp_sll_lat(s)) begin errors++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, exp_sll_lat(s)); end
        checks++; if (result !== exp) begin errors++; $display("FAIL %s_result: got %0h expected %0h", name, result, exp); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL %s_busy_in_ready: got %0d busy cycles with in_ready=1 expected 0", name, bad_ready); end
        step();
    endtask

    task automatic test_sll();
        run_sll(64'd1, 64'd3, 3, 64'd8, "sll3");
        run_sll(64'h1234, 64'd64, 0, 64'h1234, "sll0");
        run_sll(64'd3, 64'd1, 1, 64'd6, "sll1");
        run_sll(64'd1, 64'd63, 63, 64'h8000_0000_0000_0000, "sll63");
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready = 1'b0;
        drive(C_AND, 64'hF0, 64'h3C);
        step();
        drive(C_ADD, 64'd2, 64'd3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== 64'h30 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles (result=%0h in_ready=%b) expected 0", bad, result, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 64'd5) begin errors++; $display("FAIL bp_next_op: got valid=%b result=%0h expected 1 5", out_valid, result); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        int bad;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive(C_ADD, 64'(100 * (i + 1)), 64'(i));
            exp_q.push_back(64'(101 * i + 100));
            step();
            if (out_valid !== 1'b1 || result !== exp_q.pop_front()) begin
                bad++;
                $display("FAIL b2b_result_%0d: got valid=%b result=%0d expected %0d", i, out_valid, result, 101 * i + 100);
            end
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) errors++;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        drive(C_SLL, 64'h0ABC, 64'd20);
        step();
        for (int i = 0; i < 4; i++) step();
`ifndef ALU_FAST_SHIFT_EN
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midshift_busy: got valid=%b in_ready=%b expected 0 0", out_valid, in_ready); end
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || result !== 64'd0) begin errors++; $display("FAIL midshift_reset: got valid=%b result=%0h expected 0 0", out_valid, result); end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive(C_AND, 64'hFF, 64'h0F);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || result !== 64'd0) begin errors++; $display("FAIL middone_reset: got valid=%b result=%0h expected 0 0", out_valid, result); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(C_ADD, 64'd1, 64'd1);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 64'd2) begin errors++; $display("FAIL post_reset_add: got valid=%b result=%0h expected 1 2", out_valid, result); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_branch();
        test_sll();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
